// File: rtl/vga_curve_plotter_if.sv
// Configuration write port for vga_curve_plotter: valid/ready handshake
// carrying a channel index, a field select and 16 bits of data.
interface vga_curve_plotter_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_sel;
    logic [1:0]  cfg_field;
    logic [15:0] cfg_data;

    modport master (
        output cfg_valid,
        output cfg_sel,
        output cfg_field,
        output cfg_data,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_sel,
        input  cfg_field,
        input  cfg_data,
        output cfg_ready
    );
endinterface

// File: rtl/vga_curve_plotter.sv
// VGA timing generator with an N-channel y = M*x + B line-plot pipeline.
// Channel parameters are written into a shadow set and copied to the active
// set at frame start. Optional macro VGA_CURVE_PLOTTER_THICK_EN widens each
// trace to three pixels (p == y-1, y, y+1).
module vga_curve_plotter #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned N_CURVES = 4,
    parameter int unsigned COLOR_W  = 3,
    parameter int unsigned COORD_W  = 10
) (
    input  logic                clk50,
    input  logic                rst,
    vga_curve_plotter_if.slave  cfg,
    output logic [COLOR_W-1:0]  pix,
    output logic                hsync,
    output logic                vsync,
    output logic                frame_start,
    output logic [COORD_W-1:0]  counter_x,
    output logic [COORD_W-1:0]  counter_y
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] X_ACT   = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] Y_ACT   = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_BEG  = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END  = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_BEG  = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END  = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    logic               pix_en;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               commit;
    logic               accept;

    // Shadow (written by the config port) and active (used for drawing) sets
    logic [15:0]         sh_m  [N_CURVES];
    logic [15:0]         sh_b  [N_CURVES];
    logic [COLOR_W-1:0]  sh_c  [N_CURVES];
    logic [N_CURVES-1:0] sh_en;
    logic [15:0]         ac_m  [N_CURVES];
    logic [15:0]         ac_b  [N_CURVES];
    logic [COLOR_W-1:0]  ac_c  [N_CURVES];
    logic [N_CURVES-1:0] ac_en;

    // Pipeline stage 1
    logic [31:0]         prod  [N_CURVES];
    logic [31:0]         p1    [N_CURVES];
    logic [COLOR_W-1:0]  c1    [N_CURVES];
    logic [N_CURVES-1:0] en1;
    logic [COORD_W-1:0]  y1;
    logic                act1;
    logic                hs1;
    logic                vs1;

    // Pipeline stage 2 selection
    logic [31:0]         y_ext;
    logic [N_CURVES-1:0] hit;
    logic [COLOR_W-1:0]  sel_col;
    logic                found;

    assign counter_x     = x;
    assign counter_y     = y;
    assign commit        = pix_en && (x == '0) && (y == '0);
    assign cfg.cfg_ready = !commit;
    assign accept        = cfg.cfg_valid && !commit;

    // Pixel enable and raster counters
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            pix_en <= 1'b0;
            x      <= '0;
            y      <= '0;
        end else begin
            pix_en <= ~pix_en;
            if (pix_en) begin
                if (x == X_LAST) begin
                    x <= '0;
                    y <= (y == Y_LAST) ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
        end
    end

    // Config writes into the shadow set; out-of-range channel indices match no slot
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_CURVES; i++) begin
                sh_m[i] <= '0;
                sh_b[i] <= '0;
                sh_c[i] <= '0;
            end
            sh_en <= '0;
        end else begin
            for (int unsigned i = 0; i < N_CURVES; i++) begin
                if (accept && (cfg.cfg_sel == 3'(i))) begin
                    case (cfg.cfg_field)
                        2'd0:    sh_m[i]  <= cfg.cfg_data;
                        2'd1:    sh_b[i]  <= cfg.cfg_data;
                        2'd2:    sh_c[i]  <= cfg.cfg_data[COLOR_W-1:0];
                        default: sh_en[i] <= cfg.cfg_data[0];
                    endcase
                end
            end
        end
    end

    // Atomic copy of the shadow set at frame start
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_CURVES; i++) begin
                ac_m[i] <= '0;
                ac_b[i] <= '0;
                ac_c[i] <= '0;
            end
            ac_en       <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= commit;
            if (commit) begin
                for (int unsigned i = 0; i < N_CURVES; i++) begin
                    ac_m[i] <= sh_m[i];
                    ac_b[i] <= sh_b[i];
                    ac_c[i] <= sh_c[i];
                end
                ac_en <= sh_en;
            end
        end
    end

    // M*X + B per channel; the low 32 bits are identical for signed and unsigned products
    always_comb begin
        for (int unsigned i = 0; i < N_CURVES; i++) begin
            prod[i] = {{16{ac_m[i][15]}}, ac_m[i]} * {{(32-COORD_W){1'b0}}, x}
                    + {{16{ac_b[i][15]}}, ac_b[i]};
        end
    end

    // Stage 1: register line values together with the raster state they belong to
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_CURVES; i++) begin
                p1[i] <= '0;
                c1[i] <= '0;
            end
            en1  <= '0;
            y1   <= '0;
            act1 <= 1'b0;
            hs1  <= 1'b1;
            vs1  <= 1'b1;
        end else begin
            for (int unsigned i = 0; i < N_CURVES; i++) begin
                p1[i] <= prod[i];
                c1[i] <= ac_c[i];
            end
            en1  <= ac_en;
            y1   <= y;
            act1 <= (x < X_ACT) && (y < Y_ACT);
            hs1  <= !((x >= HS_BEG) && (x < HS_END));
            vs1  <= !((y >= VS_BEG) && (y < VS_END));
        end
    end

    // Hit detection and lowest-index priority select
    always_comb begin
        y_ext   = {{(32-COORD_W){1'b0}}, y1};
        sel_col = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < N_CURVES; i++) begin
`ifdef VGA_CURVE_PLOTTER_THICK_EN
            hit[i] = en1[i] && ((p1[i] == y_ext) || (p1[i] == y_ext - 32'd1)
                                || (p1[i] == y_ext + 32'd1));
`else
            hit[i] = en1[i] && (p1[i] == y_ext);
`endif
            if (!found && hit[i]) begin
                sel_col = c1[i];
                found   = 1'b1;
            end
        end
    end

    // Stage 2: registered pin outputs, syncs delayed alongside the pixel
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            pix   <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            pix   <= act1 ? sel_col : '0;
            hsync <= hs1;
            vsync <= vs1;
        end
    end
endmodule

// File: tb/tb_vga_curve_plotter.sv
// Self-checking bench for vga_curve_plotter on a reduced raster. The
// reference derives the raster position from the clock count since reset
// and evaluates the curves with plain integer arithmetic.
module tb_vga_curve_plotter;
    localparam int HA = 40, HFP = 4, HSY = 8, HBP = 4;
    localparam int VA = 30, VFP = 2, VSY = 2, VBP = 3;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FT = HT * VT;
    localparam int N  = 4;
    localparam int CW = 3;
    localparam int XW = 10;

    logic          clk50 = 1'b0;
    logic          rst   = 1'b1;
    logic [CW-1:0] pix;
    logic          hsync, vsync, frame_start;
    logic [XW-1:0] counter_x, counter_y;

    vga_curve_plotter_if cfg_bus ();

    vga_curve_plotter #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .N_CURVES(N), .COLOR_W(CW), .COORD_W(XW)
    ) dut (
        .clk50       (clk50),
        .rst         (rst),
        .cfg         (cfg_bus.slave),
        .pix         (pix),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start),
        .counter_x   (counter_x),
        .counter_y   (counter_y)
    );

    always #5 clk50 = ~clk50;

    typedef struct {
        logic [2:0]  sel;
        logic [1:0]  field;
        logic [15:0] data;
    } wr_t;

    int n_cmp = 0;
    int n_err = 0;
    int k;
    int sm [N], sb [N], sc [N], se [N];
    int am [N], ab [N], ac [N], ae [N];
    logic [CW+1:0] e1, e2;
    logic          fs_exp;
    wr_t           dq [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (clk %0d after reset)", tag, got, exp, k);
        end
    endtask

    function automatic int pos_x(input int kk);
        return (kk / 2) % HT;
    endfunction

    function automatic int pos_y(input int kk);
        return ((kk / 2) / HT) % VT;
    endfunction

    // Expected {pix, hsync, vsync} for the raster position at kk with the current active set
    function automatic logic [CW+1:0] ref_out(input int kk);
        int xx, yy, p;
        logic [CW-1:0] col;
        logic hs, vs;
        xx  = pos_x(kk);
        yy  = pos_y(kk);
        col = '0;
        hs  = !(xx >= HA + HFP && xx < HA + HFP + HSY);
        vs  = !(yy >= VA + VFP && yy < VA + VFP + VSY);
        if (xx < HA && yy < VA) begin
            for (int i = N - 1; i >= 0; i--) begin
                p = am[i] * xx + ab[i];
`ifdef VGA_CURVE_PLOTTER_THICK_EN
                if (ae[i] != 0 && (p == yy || p == yy - 1 || p == yy + 1)) col = CW'(ac[i]);
`else
                if (ae[i] != 0 && p == yy) col = CW'(ac[i]);
`endif
            end
        end
        return {col, hs, vs};
    endfunction

    task automatic model_reset();
        k = 0;
        for (int i = 0; i < N; i++) begin
            sm[i] = 0; sb[i] = 0; sc[i] = 0; se[i] = 0;
            am[i] = 0; ab[i] = 0; ac[i] = 0; ae[i] = 0;
        end
        e1     = {{CW{1'b0}}, 2'b11};
        e2     = {{CW{1'b0}}, 2'b11};
        fs_exp = 1'b0;
    endtask

    task automatic push_wr(input int sel, input int field, input int data);
        wr_t w;
        w.sel   = 3'(sel);
        w.field = 2'(field);
        w.data  = 16'(data);
        dq.push_back(w);
    endtask

    // One clock: check outputs (called after negedge), drive next write, update model at posedge
    task automatic step();
        logic rdy;
        logic [CW+1:0] f;
        wr_t w;
        int ch;
        rdy = !((k % 2 == 1) && ((k / 2) % FT == 0));
        check("counter_x", 32'(counter_x), 32'(pos_x(k)));
        check("counter_y", 32'(counter_y), 32'(pos_y(k)));
        check("cfg_ready", 32'(cfg_bus.cfg_ready), 32'(rdy));
        check("frame_start", 32'(frame_start), 32'(fs_exp));
        check("pix", 32'(pix), 32'(e2[CW+1:2]));
        check("hsync", 32'(hsync), 32'(e2[1]));
        check("vsync", 32'(vsync), 32'(e2[0]));
        f = ref_out(k);

        if (!(cfg_bus.cfg_valid && !rdy)) begin
            if (dq.size() != 0 && k >= 6) begin
                w = dq.pop_front();
                cfg_bus.cfg_valid = 1'b1;
                cfg_bus.cfg_sel   = w.sel;
                cfg_bus.cfg_field = w.field;
                cfg_bus.cfg_data  = w.data;
            end else if (dq.size() == 0 && k > 4 * FT && $urandom_range(0, 15) == 0) begin
                cfg_bus.cfg_valid = 1'b1;
                cfg_bus.cfg_sel   = 3'($urandom_range(0, 7));
                cfg_bus.cfg_field = 2'($urandom_range(0, 3));
                case (cfg_bus.cfg_field)
                    2'd0:    cfg_bus.cfg_data = 16'($signed($urandom_range(0, 6)) - 3);
                    2'd1:    cfg_bus.cfg_data = 16'($signed($urandom_range(0, 80)) - 40);
                    default: cfg_bus.cfg_data = 16'($urandom);
                endcase
            end else begin
                cfg_bus.cfg_valid = 1'b0;
            end
        end

        @(posedge clk50);
        if (cfg_bus.cfg_valid && rdy && cfg_bus.cfg_sel < N) begin
            ch = int'(cfg_bus.cfg_sel);
            case (cfg_bus.cfg_field)
                2'd0:    sm[ch] = int'($signed(cfg_bus.cfg_data));
                2'd1:    sb[ch] = int'($signed(cfg_bus.cfg_data));
                2'd2:    sc[ch] = int'(cfg_bus.cfg_data[CW-1:0]);
                default: se[ch] = int'(cfg_bus.cfg_data[0]);
            endcase
        end
        if (!rdy) begin
            am = sm; ab = sb; ac = sc; ae = se;
        end
        fs_exp = !rdy;
        k++;
        e2 = e1;
        e1 = f;
        @(negedge clk50);
    endtask

    initial begin
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_sel   = '0;
        cfg_bus.cfg_field = '0;
        cfg_bus.cfg_data  = '0;
        model_reset();

        // Directed channels: slope 2 (ch0), negative offset (ch1), diagonal (ch2)
        push_wr(0, 0, 2);  push_wr(0, 1, 0);   push_wr(0, 2, 5); push_wr(0, 3, 1);
        push_wr(1, 0, 1);  push_wr(1, 1, -20); push_wr(1, 2, 3); push_wr(1, 3, 1);
        push_wr(2, 0, 1);  push_wr(2, 1, 0);   push_wr(2, 2, 4); push_wr(2, 3, 1);
        push_wr(0, 2, 6);  push_wr(5, 2, 7);

        repeat (3) @(posedge clk50);
        @(negedge clk50);
        rst = 1'b0;
        for (int i = 0; i < 6 * FT + 2 * HT + 37; i++) step();

        // Asynchronous reset in the middle of a line
        @(posedge clk50);
        #2 rst = 1'b1;
        #1;
        check("rst_pix", 32'(pix), 32'd0);
        check("rst_hsync", 32'(hsync), 32'd1);
        check("rst_vsync", 32'(vsync), 32'd1);
        check("rst_ready", 32'(cfg_bus.cfg_ready), 32'd1);
        check("rst_x", 32'(counter_x), 32'd0);
        check("rst_y", 32'(counter_y), 32'd0);
        check("rst_fs", 32'(frame_start), 32'd0);
        cfg_bus.cfg_valid = 1'b0;
        @(negedge clk50);
        @(negedge clk50);
        rst = 1'b0;
        model_reset();
        push_wr(0, 0, 0);  push_wr(0, 1, 10);  push_wr(0, 2, 1); push_wr(0, 3, 1);
        push_wr(2, 0, 1);  push_wr(2, 1, 0);   push_wr(2, 2, 4); push_wr(2, 3, 1);
        for (int i = 0; i < 6 * FT; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
